// File: rtl/servo_slot_scheduler_if.sv
// Register-port bus between the servo slot scheduler (master) and the timer (slave).
//   write_en   : single-cycle write strobe
//   read_en    : single-cycle read strobe
//   addr       : register byte address
//   write_data : write payload
//   read_data  : read payload, valid the cycle after read_en
interface servo_slot_scheduler_if;
    logic        write_en;
    logic        read_en;
    logic [7:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output write_en,
        output read_en,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_en,
        input  read_en,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/servo_slot_scheduler.sv
// Servo slot scheduler: time-shares one timer among NCH hobby-servo channels. Each channel owns
// one SLOT_TICKS slot; its pulse rises on the timer overflow that opens the slot and falls on
// the compare match programmed with its (clamped) width.
//
// Ports:
//   i_pclk, i_reset : clock, synchronous active-high reset
//   i_start, i_stop : single-cycle control pulses (stop wins)
//   i_pw            : per-channel pulse width, channel i at [16i+15:16i], 0 = disabled
//   io_bus          : timer register port (master side)
//   i_fabint        : timer interrupt pulse
//   o_servo_out     : per-channel pulse outputs, at most one high
//   o_cur_ch        : channel owning the current slot
//   o_busy          : high whenever not idle
//   o_err           : sticky clamp / watchdog flag, cleared by reset or an accepted start
//
// Build option: define SERVO_SCHED_WDOG_EN to add a watchdog that restarts scheduling when no
// fabint is seen for 2*SLOT_TICKS cycles.
module servo_slot_scheduler #(
    parameter int unsigned NCH        = 5,
    parameter int unsigned SLOT_TICKS = 4000,
    parameter int unsigned MIN_GAP    = 16
) (
    input  logic                      i_pclk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [NCH*16-1:0]         i_pw,
    servo_slot_scheduler_if.master    io_bus,
    input  logic                      i_fabint,
    output logic [NCH-1:0]            o_servo_out,
    output logic [3:0]                o_cur_ch,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam logic [7:0]  AddrOvf  = 8'h00;
    localparam logic [7:0]  AddrCtrl = 8'h08;
    localparam logic [7:0]  AddrCmp  = 8'h0C;
    localparam logic [7:0]  AddrStat = 8'h10;
    localparam logic [31:0] OvfVal   = 32'(SLOT_TICKS - 1);
    localparam logic [31:0] CtrlRun  = 32'h0000_000F;
    localparam logic [15:0] PwMin    = 16'(MIN_GAP);
    localparam logic [15:0] PwMax    = 16'(SLOT_TICKS - MIN_GAP);
    localparam logic [3:0]  LastCh   = 4'(NCH - 1);

    typedef enum logic [3:0] {
        StIdle, StWOvf, StWCmp0, StWCtrl, StWait, StRdStat, StCap, StAct, StWCmpN, StHalt
    } state_e;

    function automatic logic [3:0] next_ch(input logic [3:0] ch);
        return (ch == LastCh) ? 4'd0 : ch + 4'd1;
    endfunction

    state_e          r_state, w_state;
    logic [3:0]      r_cur_ch, w_cur_ch;
    logic [NCH-1:0]  r_servo, w_servo;
    logic            r_err, w_err;
    logic            r_pend, w_pend;
    logic [1:0]      r_stat, w_stat;
    logic            r_en_nxt, w_en_nxt;     // enable of the channel whose compare was last written
    logic            r_cmp_seen, w_cmp_seen; // this slot's compare already handled
    logic            r_we, w_we;
    logic            r_re, w_re;
    logic [7:0]      r_addr, w_addr;
    logic [31:0]     r_wdata, w_wdata;
    logic [3:0]      w_cmp_ch;
    logic [15:0]     w_pw_sel;

`ifdef SERVO_SCHED_WDOG_EN
    localparam logic [31:0] WdogLimit = 32'(2 * SLOT_TICKS);
    logic [31:0] r_wdog, w_wdog;
`endif

    always_comb begin
        w_state    = r_state;
        w_cur_ch   = r_cur_ch;
        w_servo    = r_servo;
        w_err      = r_err;
        w_pend     = r_pend | (i_fabint && (r_state != StIdle));
        w_stat     = r_stat;
        w_en_nxt   = r_en_nxt;
        w_cmp_seen = r_cmp_seen;
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_cmp_ch   = '0;
        w_pw_sel   = '0;

        case (r_state)
            StIdle: begin
                w_pend = 1'b0;
                if (i_start) begin
                    w_state = StWOvf;
                    w_err   = 1'b0;
                end
            end
            StWOvf:  w_state = StWCmp0;
            StWCmp0: w_state = StWCtrl;
            StWCtrl: begin
                w_cur_ch   = '0;
                w_servo    = r_en_nxt ? NCH'(1) : '0;
                w_cmp_seen = 1'b0;
                w_state    = StWait;
            end
            StWait: begin
                if (i_fabint || r_pend) begin
                    w_pend  = 1'b0;
                    w_state = StRdStat;
                end
            end
            StRdStat: w_state = StCap;
            StCap: begin
                w_stat  = io_bus.read_data[1:0];
                w_state = StAct;
            end
            StAct: begin
                w_state = StWait;
                // The next channel's compare is written mid-slot and may match again before the
                // slot ends; only the first compare of a slot ends a pulse.
                if (r_stat[1] && !r_cmp_seen) begin
                    w_servo    = r_servo & ~(NCH'(1) << r_cur_ch);
                    w_cmp_seen = 1'b1;
                    w_state    = StWCmpN;
                end
                if (r_stat[0]) begin
                    w_cur_ch   = next_ch(r_cur_ch);
                    w_servo    = r_en_nxt ? (NCH'(1) << next_ch(r_cur_ch)) : '0;
                    w_cmp_seen = 1'b0;
                end
            end
            StWCmpN: w_state = StWait;
            StHalt:  w_state = StIdle;
            default: w_state = StIdle;
        endcase

`ifdef SERVO_SCHED_WDOG_EN
        w_wdog = ((r_state == StIdle) || i_fabint) ? '0 : r_wdog + 32'd1;
        if ((r_state != StIdle) && (r_state != StHalt) && (r_wdog == WdogLimit)) begin
            w_state  = StWOvf;
            w_err    = 1'b1;
            w_servo  = '0;
            w_cur_ch = '0;
            w_pend   = 1'b0;
            w_wdog   = '0;
        end
`endif

        if (i_stop) begin
            w_state = StHalt;
            w_servo = '0;
        end

        // Bus strobes are registered alongside the state they belong to.
        case (w_state)
            StWOvf: begin
                w_we    = 1'b1;
                w_addr  = AddrOvf;
                w_wdata = OvfVal;
            end
            StWCmp0, StWCmpN: begin
                w_we     = 1'b1;
                w_addr   = AddrCmp;
                w_cmp_ch = (w_state == StWCmp0) ? 4'd0 : next_ch(w_cur_ch);
                w_pw_sel = i_pw[16*w_cmp_ch +: 16];
                w_en_nxt = (w_pw_sel != '0);
                // A disabled channel still gets a harmless compare so the chain keeps advancing.
                if (w_pw_sel == '0) begin
                    w_wdata = 32'(PwMin);
                end else if (w_pw_sel < PwMin) begin
                    w_wdata = 32'(PwMin);
                    w_err   = 1'b1;
                end else if (w_pw_sel > PwMax) begin
                    w_wdata = 32'(PwMax);
                    w_err   = 1'b1;
                end else begin
                    w_wdata = 32'(w_pw_sel);
                end
            end
            StWCtrl: begin
                w_we    = 1'b1;
                w_addr  = AddrCtrl;
                w_wdata = CtrlRun;
            end
            StRdStat: begin
                w_re   = 1'b1;
                w_addr = AddrStat;
            end
            StHalt: begin
                w_we    = 1'b1;
                w_addr  = AddrCtrl;
                w_wdata = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_cur_ch   <= '0;
            r_servo    <= '0;
            r_err      <= 1'b0;
            r_pend     <= 1'b0;
            r_stat     <= '0;
            r_en_nxt   <= 1'b0;
            r_cmp_seen <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state;
            r_cur_ch   <= w_cur_ch;
            r_servo    <= w_servo;
            r_err      <= w_err;
            r_pend     <= w_pend;
            r_stat     <= w_stat;
            r_en_nxt   <= w_en_nxt;
            r_cmp_seen <= w_cmp_seen;
            r_we       <= w_we;
            r_re       <= w_re;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
        end
    end

`ifdef SERVO_SCHED_WDOG_EN
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog;
        end
    end
`endif

    assign io_bus.write_en   = r_we;
    assign io_bus.read_en    = r_re;
    assign io_bus.addr       = r_addr;
    assign io_bus.write_data = r_wdata;

    assign o_servo_out = r_servo;
    assign o_cur_ch    = r_cur_ch;
    assign o_busy      = (r_state != StIdle);
    assign o_err       = r_err;

endmodule

// File: tb/tb_servo_slot_scheduler.sv
// Directed bench for servo_slot_scheduler with a behavioural timer on the register port.
module tb_servo_slot_scheduler;

    localparam int NCH  = 5;
    localparam int SLOT = 4000;
    localparam int GAP  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              fabint;
    logic              irq_mask = 1'b0;
    logic [NCH*16-1:0] pw = '0;
    logic [NCH-1:0]    servo;
    logic [3:0]        cur_ch;
    logic              busy;
    logic              err;

    servo_slot_scheduler_if bus_if ();

    servo_slot_scheduler #(
        .NCH        (NCH),
        .SLOT_TICKS (SLOT),
        .MIN_GAP    (GAP)
    ) dut (
        .i_pclk      (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_pw        (pw),
        .io_bus      (bus_if),
        .i_fabint    (fabint),
        .o_servo_out (servo),
        .o_cur_ch    (cur_ch),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Timer: counts 0..ovf, events flagged on the edge the counter wraps / reaches compare.
    logic [31:0] t_ovf, t_ctrl, t_cmp, t_cnt, t_nxt;
    logic [1:0]  t_stat;
    logic        t_wrap, ev_o, ev_c;

    assign t_wrap = t_ctrl[0] && (t_cnt == t_ovf);
    assign t_nxt  = t_wrap ? 32'd0 : t_cnt + 32'd1;
    assign ev_o   = t_wrap && t_ctrl[3];
    assign ev_c   = t_ctrl[0] && t_ctrl[2] && (t_nxt == t_cmp);

    always @(posedge clk) begin
        if (rst) begin
            t_ovf <= 0; t_ctrl <= 0; t_cmp <= 0; t_cnt <= 0; t_stat <= 0;
            fabint <= 1'b0;
            bus_if.read_data <= 0;
        end else begin
            if (t_ctrl[0]) t_cnt <= t_nxt;
            fabint <= t_ctrl[1] && (ev_o || ev_c) && !irq_mask;
            if (bus_if.write_en) begin
                case (bus_if.addr)
                    8'h00: begin t_ovf <= bus_if.write_data; t_cnt <= 0; end
                    8'h08: t_ctrl <= bus_if.write_data;
                    8'h0C: t_cmp <= bus_if.write_data;
                    default: ;
                endcase
            end
            if (bus_if.read_en && bus_if.addr == 8'h10) begin
                bus_if.read_data <= {30'd0, t_stat};
                t_stat <= {ev_c, ev_o};
            end else begin
                t_stat <= t_stat | {ev_c, ev_o};
            end
        end
    end

    // Observation of pulses, channel changes and bus activity.
    int             cyc = 0;
    int             rise_t[NCH] = '{default: 0};
    int             width[NCH] = '{default: 0};
    int             rise_cnt[NCH] = '{default: 0};
    int             onehot_bad = 0;
    int             bus_bad = 0;
    int             ovf_wr = 0;
    logic [NCH-1:0] servo_at_ovf = '0;
    logic [NCH-1:0] servo_prev = '0;
    logic [3:0]     cur_prev = '0;
    int             cur_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(servo) > 1) onehot_bad++;
            if (bus_if.write_en && bus_if.read_en) bus_bad++;
            for (int i = 0; i < NCH; i++) begin
                if (servo[i] && !servo_prev[i]) begin
                    rise_t[i] = cyc;
                    rise_cnt[i]++;
                end else if (!servo[i] && servo_prev[i]) begin
                    width[i] = cyc - rise_t[i];
                end
            end
            if (cur_ch != cur_prev) cur_log.push_back(int'(cur_ch));
            if (bus_if.write_en && bus_if.addr == 8'h00) begin
                ovf_wr++;
                servo_at_ovf = servo;
            end
            servo_prev = servo;
            cur_prev   = cur_ch;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    int r0;
    int rc2;
    int ovf0;

    initial begin
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        check("rst_servo", 32'(servo), 0);
        check("rst_cur_ch", 32'(cur_ch), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_we", 32'(bus_if.write_en), 0);
        check("rst_re", 32'(bus_if.read_en), 0);
        check("rst_addr", 32'(bus_if.addr), 0);
        check("rst_wdata", bus_if.write_data, 0);

        // Nominal frame
        pw = {16'd1800, 16'd1200, 16'd2000, 16'd1500, 16'd1000};
        cur_log.delete();
        pulse_start();
        check("wovf_addr", 32'(bus_if.addr), 32'h00);
        check("wovf_data", bus_if.write_data, SLOT - 1);
        check("wovf_we", 32'(bus_if.write_en), 1);
        check("busy_run", 32'(busy), 1);
        step(1);
        check("wcmp0_addr", 32'(bus_if.addr), 32'h0C);
        check("wcmp0_data", bus_if.write_data, 1000);
        step(1);
        check("wctrl_addr", 32'(bus_if.addr), 32'h08);
        check("wctrl_data", bus_if.write_data, 32'h0F);
        check("wctrl_servo", 32'(servo), 0);
        step(1);
        check("first_rise", 32'(servo), 1);
        check("first_cur", 32'(cur_ch), 0);

        step(20100);
        pw[15:0] = 16'd1300;  // mid-pulse of channel 0, frame 2
        step(18900);
        check("w0_f2", width[0], 1000);
        check("w1", width[1], 1500);
        check("w2", width[2], 2000);
        check("w3", width[3], 1200);
        check("w4", width[4], 1800);
        check("slot_spacing", rise_t[2] - rise_t[1], SLOT);
        check("cur_seq0", cur_log[0], 1);
        check("cur_seq1", cur_log[1], 2);
        check("cur_seq2", cur_log[2], 3);
        check("cur_seq3", cur_log[3], 4);
        check("cur_seq4", cur_log[4], 0);
        check("err_nominal", 32'(err), 0);
        r0 = rise_t[0];
        step(2400);
        check("w0_f3", width[0], 1300);
        check("frame_period", rise_t[0] - r0, NCH * SLOT);

        // Stop in WAIT
        pulse_stop();
        check("halt_we", 32'(bus_if.write_en), 1);
        check("halt_addr", 32'(bus_if.addr), 32'h08);
        check("halt_data", bus_if.write_data, 0);
        check("halt_servo", 32'(servo), 0);
        step(1);
        check("halt_busy", 32'(busy), 0);
        check("halt_one_wr", 32'(bus_if.write_en), 0);

        // Disabled channel 2
        pw = {16'd1800, 16'd1200, 16'd0, 16'd1500, 16'd1000};
        rc2 = rise_cnt[2];
        pulse_start();
        step(3);
        check("restart_servo", 32'(servo), 1);
        check("restart_cur", 32'(cur_ch), 0);
        step(8100);
        check("dis_cur2", 32'(cur_ch), 2);
        check("dis_servo", 32'(servo), 0);
        step(4000);
        check("dis_no_rise", rise_cnt[2] - rc2, 0);
        check("dis_err", 32'(err), 0);
        pulse_stop();
        step(2);

        // Clamping
        pw = {16'd1800, 16'd3995, 16'd2000, 16'd5, 16'd1000};
        pulse_start();
        step(3);
        step(16100);
        check("clamp_lo", width[1], GAP);
        check("clamp_hi", width[3], SLOT - GAP);
        check("clamp_err", 32'(err), 1);

`ifdef SERVO_SCHED_WDOG_EN
        // Watchdog: suppress fabint
        pulse_stop();
        step(2);
        pw = {16'd1800, 16'd1200, 16'd2000, 16'd1500, 16'd1000};
        ovf0 = ovf_wr;
        irq_mask = 1'b1;
        pulse_start();
        check("wd_err_clr", 32'(err), 0);
        step(8100);
        check("wd_err", 32'(err), 1);
        check("wd_ovf_rewrite", ovf_wr - ovf0, 2);
        check("wd_servo_off", 32'(servo_at_ovf), 0);
        check("wd_cur", 32'(cur_ch), 0);
        check("wd_restart", 32'(servo), 1);
        irq_mask = 1'b0;
`endif

        check("onehot", onehot_bad, 0);
        check("bus_excl", bus_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servo_slot_scheduler.md
# servo_slot_scheduler

Bus-master sequencer that time-shares one `timer` instance among NCH servo channels to produce hobby-servo PWM for the hand's finger actuators. It sits between the fabric and the timer's register port. It programs overflow, compare and control over that port, services `fabint` by reading and clearing the interrupt status, and drives one pulse output per channel. Each channel in turn owns one slot of SLOT_TICKS cycles, so the frame is NCH×SLOT_TICKS cycles.

## Interface
- NCH, 5: number of servo channels (2..16).
- SLOT_TICKS, 4000: slot length in pclk cycles; written to the timer overflow register as SLOT_TICKS-1.
- MIN_GAP, 16: minimum distance in cycles between a pulse edge and a slot boundary.
- pclk  in  1  clock; one clock for the block.
- reset  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; begins scheduling from IDLE.
- stop  in  1  single-cycle pulse; halts the timer and returns to IDLE.
- pw  in  NCH*16  per-channel pulse width in cycles; channel i is at [16i+15:16i].
- bus_write_en  out  1  timer register write strobe, one cycle.
- bus_read_en  out  1  timer register read strobe, one cycle.
- bus_addr  out  8  timer register byte address.
- bus_write_data  out  32  timer write data.
- bus_read_data  in  32  timer read data; valid the cycle after bus_read_en.
- fabint  in  1  timer interrupt pulse.
- servo_out  out  NCH  pulse outputs; at most one bit high at a time.
- cur_ch  out  4  index of the channel owning the current slot.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag for clamp or watchdog events; cleared only by reset or start.

## Operation
- Timer map: overflow 0x00, control 0x08, compare 0x0C, status 0x10. Status bit0 = overflow, bit1 = compare. Reading status clears it.
- Reset values: all bus strobes 0, bus_addr 0, bus_write_data 0, servo_out 0, cur_ch 0, busy 0, err 0. State is IDLE.
- Width rule: `pw[i]` is clamped into [MIN_GAP, SLOT_TICKS-MIN_GAP]. A clamp sets err. `pw[i]`==0 means the channel is disabled: no edge is produced and nothing is clamped.
- Width latching: a channel's width is latched when its compare value is written. Changes to `pw` mid-pulse take effect in the next frame.
- States and transitions:
  - IDLE -> start -> W_OVF.
  - W_OVF: write 0x00 = SLOT_TICKS-1. This also zeroes the timer counter.
  - W_CMP0: write 0x0C = clamp(pw[0]).
  - W_CTRL: write 0x08 = 0x0F (timer enable, interrupt enable, compare enable, overflow enable). In the same cycle set cur_ch=0 and drive servo_out[0] high if pw[0]≠0.
  - W_CTRL -> WAIT.
  - WAIT -> fabint or pending flag -> RD_STAT.
  - RD_STAT: read 0x10.
  - CAP: sample bus_read_data[1:0], then go to ACT.
  - ACT:
    - Compare bit set: clear servo_out[cur_ch].
    - Overflow bit set: advance cur_ch = (cur_ch+1) mod NCH and set servo_out to one-hot(cur_ch) if that channel's pw≠0.
    - If compare was set: go to W_CMPN. Otherwise go to WAIT.
  - W_CMPN: write 0x0C = clamp(pw[(cur_ch+1) mod NCH]), then go to WAIT.
  - stop in any state -> HALT.
  - HALT: write 0x08 = 0, servo_out = 0, then go to IDLE.
- Simultaneous events:
  - If both status bits are set in one read, handle compare first, then overflow. This yields the final one-hot for the new channel.
  - A fabint arriving in a non-WAIT state sets a pending flag, which is consumed on the next entry to WAIT. A second fabint while pending is already set is not lost, because the status read returns both bits.
  - start while busy is ignored. stop and start in the same cycle: stop wins.
- Reset mid-operation returns to IDLE with outputs at reset values. It does not write the timer; software or the next start reprograms it.

## Timing
- Bus writes and reads are single-cycle strobes, never asserted together. Consecutive bus operations are at least one cycle apart.
- Every edge on servo_out lags its timer event by the same fixed latency: counter match -> timer_interrupt -> fabint -> RD_STAT -> CAP -> ACT, registered. The high time is therefore exactly clamp(pw) cycles and the slot period exactly SLOT_TICKS cycles.
- Start to first rising edge is 4 cycles: W_OVF, W_CMP0, W_CTRL, then the registered output.
- The compare write for the next channel completes within 3 cycles of ACT. This is well inside the MIN_GAP margin.

## Configuration
- SERVO_SCHED_WDOG_EN defined:
  - A watchdog counter runs while busy and reloads on every fabint.
  - If it reaches 2×SLOT_TICKS, set err, clear servo_out, and restart at W_OVF with cur_ch=0.
- SERVO_SCHED_WDOG_EN undefined:
  - No counter is built. WAIT waits indefinitely for fabint.

## Test plan
- NCH=5, SLOT_TICKS=4000, pw={1000,1500,2000,1200,1800}, start -> servo_out[i] high for exactly pw[i] cycles, rising edges 4000 cycles apart, frame period 20000; cur_ch sequence 0,1,2,3,4,0.
- pw[2]=0 -> servo_out[2] stays low through slot 2; cur_ch still visits 2; err stays 0.
- pw[1]=5 and pw[3]=3995 -> widths 16 and 3984; err=1 after the first frame.
- Change pw[0] from 1000 to 1300 mid-pulse of channel 0 -> current pulse is 1000 cycles, the next frame's pulse is 1300.
- stop during WAIT -> one write of 0x08=0, servo_out=0 the next cycle, busy falls; a later start resumes at channel 0.
- With SERVO_SCHED_WDOG_EN, force fabint low for 8000 cycles -> err=1, servo_out=0, a write to 0x00 is reissued, and scheduling restarts at channel 0.
